fifo_ctrl: RTL and testbench

//  Pointer/flag controller that drives the memoria RAM (wr_ptr, rd_ptr) to form a synchronous FIFO.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ptr.sv | 23 ++
 rtl/fifo_ctrl.sv | 96 +++++++++
 tb/tb_fifo_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the FIFO pointer/flag controller.
// Used by fifo_ctrl and fifo_ptr.
package fifo_pkg;

    // Default RAM address width. The RAM has 2**aw slots.
    localparam int FIFO_DEFAULT_AW = 8;

    // Pointer/count type at the default width.
    typedef logic [FIFO_DEFAULT_AW-1:0] fifo_ptr_t;

    // Flags decoded from the registered occupancy count.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Usable capacity. One RAM slot always stays free because the RAM writes
    // every cycle, so wr_ptr must never point at an unread entry.
    function automatic int fifo_cap(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping ADDR_WIDTH-bit pointer with an increment enable and
// asynchronous active-high reset. Wraps from 2**ADDR_WIDTH-1 back to 0.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_DEFAULT_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // Advance by one on each accepted request; natural overflow gives the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns a write-every-cycle RAM into a
// synchronous FIFO. Owns push/pop acceptance, occupancy count, full/empty and
// threshold flags. Optional macro FIFO_CTRL_ERROR_EN enables a sticky
// overflow/underflow error flag; without it error is tied to 0.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_DEFAULT_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] af_thresh,
    input  logic [ADDR_WIDTH-1:0] ae_thresh,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH-1:0] fifo_count,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(fifo_cap(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] count;
    fifo_flags_t           flags;
    logic                  push_ok;
    logic                  pop_ok;

    // A pop only frees a slot when there is something to pop; no fall-through
    // on an empty FIFO, so a simultaneous push still sees the FIFO as it is.
    assign pop_ok  = pop & ~flags.empty;
    assign push_ok = push & (~flags.full | pop);

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    // Occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
        end
    end

    // Flags come only from the registered count, never from push/pop.
    always_comb begin
        flags              = '0;
        flags.full         = (count == CAP);
        flags.empty        = (count == '0);
        flags.almost_full  = (count >= af_thresh);
        flags.almost_empty = (count <= ae_thresh);
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign fifo_count   = count;

`ifdef FIFO_CTRL_ERROR_EN
    logic err_q;

    // Sticky error: overflow is a push refused while full, underflow is any
    // pop while empty. Cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((push && flags.full && !pop) || (pop && flags.empty)) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl (ADDR_WIDTH=3) with a
// behavioural write-every-cycle RAM and a queue-based reference model.
module tb_fifo_ctrl;

    localparam int AW  = 3;
    localparam int CAP = 7;
    localparam int AF  = 6;
    localparam int AE  = 1;
`ifdef FIFO_CTRL_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [AW-1:0] af_thresh;
    logic [AW-1:0] ae_thresh;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW-1:0] fifo_count;
    logic          error;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic [7:0]    ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] q[$];
    int         wc;
    int         rc;
    bit         err_m;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .error        (error)
    );

    // RAM stand-in: writes every edge at wr_ptr, reads combinationally at rd_ptr.
    always @(posedge clk) ram[wr_ptr] <= din;
    assign dout = ram[rd_ptr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        wc    = 0;
        rc    = 0;
        err_m = 1'b0;
    endtask

    // Compare every observable against the model.
    task automatic check_state(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ":count"}, 32'(fifo_count), 32'(sz));
        chk({tag, ":empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ":full"},  32'(full),  32'(sz == CAP));
        chk({tag, ":af"},    32'(almost_full),  32'(sz >= AF));
        chk({tag, ":ae"},    32'(almost_empty), 32'(sz <= AE));
        chk({tag, ":wr_ptr"}, 32'(wr_ptr), 32'(wc % (1 << AW)));
        chk({tag, ":rd_ptr"}, 32'(rd_ptr), 32'(rc % (1 << AW)));
        chk({tag, ":error"},  32'(error),  32'(err_m));
        if (sz > 0) begin
            chk({tag, ":head"}, 32'(dout), 32'(q[0]));
            chk({tag, ":ptr_ne"}, 32'(wr_ptr != rd_ptr), 32'd1);
        end
    endtask

    // One clock with given request; called at posedge+1, returns at posedge+1.
    task automatic cycle(input string tag, input logic p, input logic o, input logic [7:0] d);
        bit full_m;
        bit empty_m;
        bit pop_ok;
        bit push_ok;
        push    = p;
        pop     = o;
        din     = d;
        full_m  = (q.size() == CAP);
        empty_m = (q.size() == 0);
        pop_ok  = o && !empty_m;
        push_ok = p && (!full_m || o);
        if (ERR_EN && ((p && full_m && !o) || (o && empty_m))) err_m = 1'b1;
        if (pop_ok) begin
            chk({tag, ":pop_data"}, 32'(dout), 32'(q[0]));
            void'(q.pop_front());
            rc++;
        end
        if (push_ok) begin
            q.push_back(d);
            wc++;
        end
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_state(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_state(tag);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        din       = 8'h00;
        af_thresh = AW'(AF);
        ae_thresh = AW'(AE);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b0;

        // single word round trip
        cycle("push_a5", 1'b1, 1'b0, 8'hA5);
        chk("a5_out", 32'(dout), 32'hA5);
        cycle("pop_a5", 1'b0, 1'b1, 8'h00);
        chk("a5_rd_ptr", 32'(rd_ptr), 32'd1);

        // fill to full, overflow, drain
        pulse_reset("rst1");
        for (int i = 0; i < CAP; i++) begin
            cycle("fill", 1'b1, 1'b0, 8'(8'h10 + i));
            if (i == 5) chk("af_at6", 32'(almost_full), 32'd1);
        end
        chk("full_at7", 32'(full), 32'd1);
        cycle("overflow", 1'b1, 1'b0, 8'h17);
        chk("ovf_wr_ptr", 32'(wr_ptr), 32'd7);
        chk("ovf_error", 32'(error), 32'(ERR_EN));
        for (int i = 0; i < CAP; i++) begin
            chk("drain_val", 32'(dout), 32'(8'h10 + i));
            cycle("drain", 1'b0, 1'b1, 8'h00);
        end

        // full with simultaneous push/pop: pointers wrap, order kept
        for (int i = 0; i < CAP; i++) cycle("refill", 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) begin
            cycle("full_pp", 1'b1, 1'b1, 8'(8'h60 + i));
            chk("full_pp_cnt", 32'(fifo_count), 32'd7);
        end
        for (int i = 0; i < CAP; i++) cycle("drain2", 1'b0, 1'b1, 8'h00);

        // empty with push and pop together: only push lands
        pulse_reset("rst2");
        cycle("empty_pp", 1'b1, 1'b1, 8'h33);
        chk("empty_pp_cnt", 32'(fifo_count), 32'd1);
        chk("empty_pp_err", 32'(error), 32'(ERR_EN));

        // mid-operation asynchronous reset, then fresh data only
        pulse_reset("rst3");
        for (int i = 0; i < 5; i++) cycle("fill5", 1'b1, 1'b0, 8'(8'hC0 + i));
        pulse_reset("rst_mid");
        cycle("post_push", 1'b1, 1'b0, 8'h5A);
        chk("post_data", 32'(dout), 32'h5A);
        cycle("post_pop", 1'b0, 1'b1, 8'h00);

        // randomized traffic with bias phases to reach both full and empty
        for (int i = 0; i < 2000; i++) begin
            int pp;
            pp = ((i / 200) % 2 == 0) ? 75 : 25;
            cycle("rand", ($urandom_range(99) < pp), ($urandom_range(99) < (100 - pp)),
                  8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
